// File: rtl/mux_scan_reg_if.sv
// ----------------------------------------------------------------------------
// mux_scan_reg_if
// Bundles the channel-selector data path and its valid/ready output stage.
//   d         N*W  channel data, channel i at d[i*W +: W]
//   in_valid  N    per-channel valid
//   select    SW   manual channel index
//   mode      1    0 = manual, 1 = auto-scan
//   out       W    registered selected data
//   out_ch    SW   channel index that out came from
//   out_valid 1    out holds a valid word
//   out_ready 1    consumer accepts out when out_valid & out_ready
// master: the environment (sources + consumer); slave: the selector block.
// ----------------------------------------------------------------------------
interface mux_scan_reg_if #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = 2
);
    logic [N*W-1:0] d;
    logic [N-1:0]   in_valid;
    logic [SW-1:0]  select;
    logic           mode;
    logic [W-1:0]   out;
    logic [SW-1:0]  out_ch;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output d, in_valid, select, mode, out_ready,
        input  out, out_ch, out_valid
    );

    modport slave (
        input  d, in_valid, select, mode, out_ready,
        output out, out_ch, out_valid
    );
endinterface

// File: rtl/mux_scan_reg.sv
// ----------------------------------------------------------------------------
// mux_scan_reg
// Registered N-channel, W-bit channel selector with a valid/ready output
// stage. The effective channel is either the manual select or a timed
// round-robin scan pointer that stays DWELL cycles on each channel.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    mux_scan_reg_if.slave (d, in_valid, select, mode, out_ready in;
//          out, out_ch, out_valid out)
// ----------------------------------------------------------------------------
module mux_scan_reg #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SW    = 2,
    parameter int DWELL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_reg_if.slave  bus
);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SW-1:0]   scan_ptr;
    logic [DW_W-1:0] dwell;

    logic [SW-1:0]   ch;
    logic            ch_ok;
    logic [W-1:0]    ch_data;
    logic            ch_vld;
    logic            sel_ok;
    logic            ld;

    logic [W-1:0]    out_p1;
    logic [SW-1:0]   out_ch_p1;
    logic            vld_p1;

    // Stage 0: channel choice and data/valid mux. The compare loop only
    // ever touches existing channels, so an out-of-range index yields
    // zero data and no valid instead of reading past d.
    always_comb begin
        ch      = bus.mode ? scan_ptr : bus.select;
        ch_ok   = 1'b0;
        ch_data = '0;
        ch_vld  = 1'b0;
        sel_ok  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ch == SW'(i)) begin
                ch_ok   = 1'b1;
                ch_data = bus.d[i*W +: W];
                ch_vld  = bus.in_valid[i];
            end
            if (bus.select == SW'(i)) begin
                sel_ok = 1'b1;
            end
        end
    end

    // A held word may only be replaced once it has been taken.
    assign ld = !vld_p1 || bus.out_ready;

    // Stage 1: output register and scan state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_p1    <= '0;
            out_ch_p1 <= '0;
            vld_p1    <= 1'b0;
            scan_ptr  <= '0;
            dwell     <= '0;
        end else begin
            if (ld) begin
                out_p1    <= ch_data;
                out_ch_p1 <= ch;
                vld_p1    <= ch_vld && ch_ok;
            end
            // Dwell is purely time-based: stalls and in_valid do not pause it.
            // In manual mode the pointer follows select so a later scan
            // starts from the channel the user was looking at.
            if (!bus.mode) begin
                scan_ptr <= sel_ok ? bus.select : '0;
                dwell    <= '0;
            end else if (dwell == DW_W'(DWELL - 1)) begin
                dwell    <= '0;
                scan_ptr <= (scan_ptr == SW'(N - 1)) ? '0 : scan_ptr + 1'b1;
            end else begin
                dwell    <= dwell + 1'b1;
            end
        end
    end

    assign bus.out       = out_p1;
    assign bus.out_ch    = out_ch_p1;
    assign bus.out_valid = vld_p1;
endmodule
